// File: rtl/ddram_responder.sv
// Memory-side DDRAM responder backed by a 2^AW x 64 array; reads return after READ_LAT cycles.
// Bursts run back to back. BUSY (waitrequest) is high during reads and on injected stall cycles.
module ddram_responder #(
    parameter int    AW          = 12,
    parameter int    READ_LAT    = 3,
    parameter int    MAX_BURST   = 8,
    parameter int    STALL_EVERY = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        DDRAM_CLK,
    input  logic        reset,
    output logic        DDRAM_BUSY,
    input  logic [7:0]  DDRAM_BURSTCNT,
    input  logic [28:0] DDRAM_ADDR,
    input  logic        DDRAM_RD,
    output logic [63:0] DDRAM_DOUT,
    output logic        DDRAM_DOUT_READY,
    input  logic [63:0] DDRAM_DIN,
    input  logic [7:0]  DDRAM_BE,
    input  logic        DDRAM_WE,
    output logic        err_proto
);

    localparam int         DEPTH   = 1 << AW;
    localparam int         SCW     = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
    localparam logic [7:0] MAX_LEN = 8'(MAX_BURST);
    localparam logic [3:0] LAT1    = 4'(READ_LAT - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST} state_t;

    state_t          state;
    logic [AW-1:0]   addr_q;
    logic [7:0]      rem_q;
    logic [3:0]      lat_q;
    logic            stall;
    logic [7:0]      len_req;
    logic            burst_err;
    logic            wr_first;
    logic            wr_next;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic            unused_addr_hi;

    logic [63:0] mem [DEPTH] = '{default: '0};

    assign unused_addr_hi = ^DDRAM_ADDR[28:AW];

    generate
        if (STALL_EVERY > 0) begin : g_stall
            logic [SCW-1:0] stall_cnt;
            always_ff @(posedge DDRAM_CLK) begin
                if (reset)
                    stall_cnt <= '0;
                else if (stall_cnt == SCW'(STALL_EVERY - 1))
                    stall_cnt <= '0;
                else
                    stall_cnt <= stall_cnt + SCW'(1);
            end
            assign stall = (stall_cnt == SCW'(STALL_EVERY - 1));
        end else begin : g_nostall
            assign stall = 1'b0;
        end
    endgenerate

    // Stall only matters in IDLE/WR_BURST; the read states are busy regardless.
    assign DDRAM_BUSY = reset | stall | (state == RD_WAIT) | (state == RD_BURST);

    always_comb begin
        burst_err = (DDRAM_BURSTCNT > MAX_LEN);
        if (DDRAM_BURSTCNT == 8'd0)
            len_req = 8'd1;
        else if (burst_err)
            len_req = MAX_LEN;
        else
            len_req = DDRAM_BURSTCNT;
    end

    assign wr_first  = (state == IDLE) & DDRAM_WE & ~DDRAM_RD & ~DDRAM_BUSY;
    assign wr_next   = (state == WR_BURST) & DDRAM_WE & ~DDRAM_BUSY;
    assign mem_we    = wr_first | wr_next;
    assign mem_waddr = wr_first ? DDRAM_ADDR[AW-1:0] : addr_q;

    always_ff @(posedge DDRAM_CLK) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (DDRAM_BE[b]) mem[mem_waddr][8*b +: 8] <= DDRAM_DIN[8*b +: 8];
            end
        end
    end

    always_ff @(posedge DDRAM_CLK) begin
        if (reset) begin
            state            <= IDLE;
            addr_q           <= '0;
            rem_q            <= '0;
            lat_q            <= '0;
            DDRAM_DOUT       <= '0;
            DDRAM_DOUT_READY <= 1'b0;
            err_proto        <= 1'b0;
        end else begin
            DDRAM_DOUT_READY <= 1'b0;
            case (state)
                IDLE: begin
                    if (!DDRAM_BUSY && DDRAM_RD) begin
                        addr_q <= DDRAM_ADDR[AW-1:0];
                        rem_q  <= len_req;
                        lat_q  <= LAT1;
                        state  <= (READ_LAT <= 1) ? RD_BURST : RD_WAIT;
                        if (DDRAM_WE || burst_err) err_proto <= 1'b1;
                    end else if (!DDRAM_BUSY && DDRAM_WE) begin
                        addr_q <= DDRAM_ADDR[AW-1:0] + AW'(1);
                        rem_q  <= len_req - 8'd1;
                        if (burst_err) err_proto <= 1'b1;
                        if (len_req > 8'd1) state <= WR_BURST;
                    end
                end
                RD_WAIT: begin
                    lat_q <= lat_q - 4'd1;
                    if (lat_q <= 4'd1) state <= RD_BURST;
                end
                RD_BURST: begin
                    // Returning to IDLE on the last beat drops BUSY alongside DOUT_READY.
                    DDRAM_DOUT       <= mem[addr_q];
                    DDRAM_DOUT_READY <= 1'b1;
                    addr_q           <= addr_q + AW'(1);
                    rem_q            <= rem_q - 8'd1;
                    if (rem_q <= 8'd1) state <= IDLE;
                end
                WR_BURST: begin
                    if (DDRAM_RD) err_proto <= 1'b1;
                    if (wr_next) begin
                        addr_q <= addr_q + AW'(1);
                        rem_q  <= rem_q - 8'd1;
                        if (rem_q <= 8'd1) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddram_responder.sv
// Scoreboard bench: dut0 runs without stalls, dut1 with STALL_EVERY=4; a negedge monitor
// pops expected beats (data and arrival cycle) whenever DOUT_READY is high.
module tb_ddram_responder;

    localparam int RL = 3;

    typedef struct {
        logic [63:0] dat;
        int          cyc;
        bit          last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst  [2];
    logic        busy [2];
    logic [7:0]  bc   [2];
    logic [28:0] ad   [2];
    logic        rd   [2];
    logic [63:0] dout [2];
    logic        drdy [2];
    logic [63:0] din  [2];
    logic [7:0]  be   [2];
    logic        we   [2];
    logic        err  [2];

    exp_t        q0[$];
    exp_t        q1[$];
    logic [63:0] exq[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          m1    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) m1 <= rst[1] ? 0 : ((m1 == 3) ? 0 : m1 + 1);

    ddram_responder #(.AW(12), .READ_LAT(RL), .MAX_BURST(8), .STALL_EVERY(0), .INIT_FILE("")) dut0 (
        .DDRAM_CLK(clk), .reset(rst[0]), .DDRAM_BUSY(busy[0]), .DDRAM_BURSTCNT(bc[0]),
        .DDRAM_ADDR(ad[0]), .DDRAM_RD(rd[0]), .DDRAM_DOUT(dout[0]), .DDRAM_DOUT_READY(drdy[0]),
        .DDRAM_DIN(din[0]), .DDRAM_BE(be[0]), .DDRAM_WE(we[0]), .err_proto(err[0]));

    ddram_responder #(.AW(12), .READ_LAT(RL), .MAX_BURST(8), .STALL_EVERY(4), .INIT_FILE("")) dut1 (
        .DDRAM_CLK(clk), .reset(rst[1]), .DDRAM_BUSY(busy[1]), .DDRAM_BURSTCNT(bc[1]),
        .DDRAM_ADDR(ad[1]), .DDRAM_RD(rd[1]), .DDRAM_DOUT(dout[1]), .DDRAM_DOUT_READY(drdy[1]),
        .DDRAM_DIN(din[1]), .DDRAM_BE(be[1]), .DDRAM_WE(we[1]), .err_proto(err[1]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, expv);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s", nm);
    endtask

    task automatic mon(input int d);
        exp_t e;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_vec++;
            n_err++;
            $display("FAIL beat%0d: unexpected DOUT_READY at cycle %0d, dout %h", d, cyc, dout[d]);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("dout%0d", d), dout[d], e.dat);
        chk($sformatf("beat_cycle%0d", d), 64'(cyc), 64'(e.cyc));
        if (e.last && d == 0) chk("busy_with_last_beat", 64'(busy[0]), 64'd0);
    endtask

    always @(negedge clk) begin
        if (drdy[0]) mon(0);
        if (drdy[1]) mon(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_free(input int d);
        for (int n = 0; n < 200 && busy[d]; n++) tick();
        if (busy[d]) fail_now($sformatf("busy_timeout%0d", d));
    endtask

    task automatic ex(input logic [63:0] v);
        exq.push_back(v);
    endtask

    // gap: 0 none, 1 idle cycle after the first beat, 2 that cycle also drives RD.
    task automatic wr_burst(input int d, input logic [28:0] a, input int len,
                            input logic [63:0] base, input logic [7:0] bev, input int gap);
        for (int i = 0; i < len; i++) begin
            we[d]  = 1'b1;
            din[d] = base + 64'(i);
            be[d]  = bev;
            bc[d]  = 8'(len);
            ad[d]  = (i == 0) ? a : 29'h1FFF_FFFF;
            wait_free(d);
            tick();
            we[d] = 1'b0;
            if (gap > 0 && i == 0) begin
                rd[d] = (gap == 2);
                tick();
                rd[d] = 1'b0;
            end
        end
    endtask

    task automatic rd_req(input int d, input logic [28:0] a, input logic [7:0] cnt, input bit also_we);
        exp_t e;
        wait_free(d);
        rd[d]  = 1'b1;
        we[d]  = also_we;
        din[d] = 64'hDEAD;
        be[d]  = 8'hFF;
        ad[d]  = a;
        bc[d]  = cnt;
        for (int i = 0; i < exq.size(); i++) begin
            e.dat  = exq[i];
            e.cyc  = cyc + 1 + RL + i;
            e.last = (i == exq.size() - 1);
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        exq.delete();
        tick();
        rd[d] = 1'b0;
        we[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        for (int n = 0; n < 100 && ((d == 0) ? q0.size() : q1.size()) > 0; n++) tick();
        if (((d == 0) ? q0.size() : q1.size()) > 0) begin
            fail_now($sformatf("missing_beats%0d", d));
            if (d == 0) q0.delete();
            else        q1.delete();
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; rd[d] = 1'b0; we[d] = 1'b0;
            bc[d] = 8'd1; ad[d] = '0; din[d] = '0; be[d] = 8'hFF;
        end
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            chk("reset_busy", 64'(busy[d]), 64'd1);
            chk("reset_drdy", 64'(drdy[d]), 64'd0);
            chk("reset_dout", dout[d], 64'd0);
            chk("reset_err",  64'(err[d]), 64'd0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick();
        chk("idle_busy", 64'(busy[0]), 64'd0);

        // Single write then single read.
        wr_burst(0, 29'd5, 1, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
        ex(64'h0123_4567_89AB_CDEF);
        rd_req(0, 29'd5, 8'd1, 1'b0);
        drain(0);

        // Four-beat burst write with a WE gap, then burst read.
        wr_burst(0, 29'd8, 4, 64'h10, 8'hFF, 1);
        for (int i = 0; i < 4; i++) ex(64'h10 + 64'(i));
        rd_req(0, 29'd8, 8'd4, 1'b0);
        drain(0);

        // Byte enables.
        wr_burst(0, 29'd2, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
        wr_burst(0, 29'd2, 1, 64'h0, 8'h0F, 0);
        ex(64'hFFFF_FFFF_0000_0000);
        rd_req(0, 29'd2, 8'd1, 1'b0);
        drain(0);

        // Wrap at the top of the array; upper address bits ignored.
        wr_burst(0, 29'hFFF, 3, 64'hA0, 8'hFF, 0);
        ex(64'hA0); ex(64'hA1); ex(64'hA2);
        rd_req(0, 29'h1000_0FFF, 8'd3, 1'b0);
        drain(0);

        // BURSTCNT 0 means one beat.
        ex(64'h0123_4567_89AB_CDEF);
        rd_req(0, 29'd5, 8'd0, 1'b0);
        drain(0);
        chk("err_clean", 64'(err[0]), 64'd0);

        // BURSTCNT 20 clamps to 8.
        for (int i = 0; i < 4; i++) ex(64'h10 + 64'(i));
        for (int i = 0; i < 4; i++) ex(64'h0);
        rd_req(0, 29'd8, 8'd20, 1'b0);
        drain(0);
        chk("err_clamp", 64'(err[0]), 64'd1);

        // Reset one cycle after the first beat of a 4-beat read.
        for (int i = 0; i < 4; i++) ex(64'h10 + 64'(i));
        rd_req(0, 29'd8, 8'd4, 1'b0);
        for (int n = 0; n < 20 && q0.size() > 3; n++) tick();
        chk("first_beat_seen", 64'(q0.size()), 64'd3);
        rst[0] = 1'b1;
        q0.delete();
        tick();
        chk("midreset_busy", 64'(busy[0]), 64'd1);
        chk("midreset_drdy", 64'(drdy[0]), 64'd0);
        chk("midreset_dout", dout[0], 64'd0);
        chk("midreset_err",  64'(err[0]), 64'd0);
        tick();
        chk("midreset_busy2", 64'(busy[0]), 64'd1);
        rst[0] = 1'b0;
        tick();
        chk("postreset_busy", 64'(busy[0]), 64'd0);
        repeat (6) tick();
        ex(64'h11);
        rd_req(0, 29'd9, 8'd1, 1'b0);
        drain(0);

        // RD and WE together: read wins, nothing written, error flagged.
        ex(64'h10);
        rd_req(0, 29'd8, 8'd1, 1'b1);
        drain(0);
        chk("err_rdwe", 64'(err[0]), 64'd1);
        ex(64'h10);
        rd_req(0, 29'd8, 8'd1, 1'b0);
        drain(0);

        // Stall injection on dut1.
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("stall_pattern%0d", i), 64'(busy[1]), 64'(m1 == 3));
            tick();
        end
        for (int i = 0; i < 12; i++) wr_burst(1, 29'(20 + i), 1, 64'h500 + 64'(i), 8'hFF, 0);
        wr_burst(1, 29'd40, 8, 64'h600, 8'hFF, 1);
        for (int i = 0; i < 8; i++) ex(64'h500 + 64'(i));
        rd_req(1, 29'd20, 8'd8, 1'b0);
        drain(1);
        for (int i = 8; i < 12; i++) ex(64'h500 + 64'(i));
        rd_req(1, 29'd28, 8'd4, 1'b0);
        drain(1);
        for (int i = 0; i < 8; i++) ex(64'h600 + 64'(i));
        rd_req(1, 29'd40, 8'd8, 1'b0);
        drain(1);
        chk("err1_clean", 64'(err[1]), 64'd0);

        // RD inside a write burst is ignored but flagged.
        wr_burst(1, 29'd100, 2, 64'h700, 8'hFF, 2);
        chk("err1_rd_in_wr", 64'(err[1]), 64'd1);
        ex(64'h700); ex(64'h701);
        rd_req(1, 29'd100, 8'd2, 1'b0);
        drain(1);

        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
